// File: rtl/midi_msg_parser.sv
// MIDI channel-message parser with running status and a one-entry output.
// Ports: clk/rst, rx_byte/rx_valid in, msg_* ready/valid out, overflow/drop_count.
module midi_msg_parser #(
  parameter bit NOTE_ON_ZERO_IS_OFF = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic       msg_valid,
  input  logic       msg_ready,
  output logic [2:0] msg_kind,
  output logic [3:0] msg_chan,
  output logic [6:0] msg_d1,
  output logic [6:0] msg_d2,
  output logic       overflow,
  output logic [7:0] drop_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_D1    = 2'd1;
  localparam logic [1:0] S_D2    = 2'd2;
  localparam logic [1:0] S_SYSEX = 2'd3;

  logic [1:0] r_state;
  // running status without bit 7; only meaningful outside IDLE/SYSEX
  logic [6:0] r_rs;
  logic [6:0] r_d1;

  logic       w_rt;
  logic       w_sx;
  logic       w_sc;
  logic       w_st;
  logic       w_data;
  logic       w_one;
  logic       w_done;
  logic [6:0] w_cd1;
  logic [6:0] w_cd2;
  logic [2:0] w_kind;
  logic       w_load;

  assign w_rt   = rx_byte[7:3] == 5'b11111;
  assign w_sx   = rx_byte == 8'hF0;
  assign w_sc   = rx_byte[7:4] == 4'hF && !w_rt && !w_sx;
  assign w_st   = rx_byte[7] && rx_byte[7:4] != 4'hF;
  assign w_data = !rx_byte[7];

  // PROG and CHAN_AT carry a single data byte
  assign w_one  = r_rs[6:5] == 2'b10;

  assign w_done = rx_valid && w_data &&
                  ((r_state == S_D1 && w_one) || r_state == S_D2);

  assign w_cd1  = (r_state == S_D1) ? rx_byte[6:0] : r_d1;
  assign w_cd2  = (r_state == S_D1) ? 7'd0 : rx_byte[6:0];

  assign w_kind = (NOTE_ON_ZERO_IS_OFF && r_rs[6:4] == 3'd1 && w_cd2 == 7'd0)
                ? 3'd0 : r_rs[6:4];

  assign w_load = w_done && (!msg_valid || msg_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rs       <= 7'd0;
      r_d1       <= 7'd0;
      msg_valid  <= 1'b0;
      msg_kind   <= 3'd0;
      msg_chan   <= 4'd0;
      msg_d1     <= 7'd0;
      msg_d2     <= 7'd0;
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      if (rx_valid) begin
        unique case (1'b1)
          w_rt: ;
          w_sx: begin
            r_rs    <= 7'd0;
            r_state <= S_SYSEX;
          end
          w_sc: begin
            r_rs    <= 7'd0;
            r_state <= S_IDLE;
          end
          w_st: begin
            r_rs    <= rx_byte[6:0];
            r_state <= S_D1;
          end
          w_data: begin
            if (r_state == S_D1 && !w_one) begin
              r_d1    <= rx_byte[6:0];
              r_state <= S_D2;
            end else if (r_state == S_D2) begin
              r_state <= S_D1;
            end
          end
          default: ;
        endcase
      end

      if (w_load) begin
        msg_valid <= 1'b1;
        msg_kind  <= w_kind;
        msg_chan  <= r_rs[3:0];
        msg_d1    <= w_cd1;
        msg_d2    <= w_cd2;
      end else if (w_done) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF)
          drop_count <= drop_count + 8'd1;
      end else if (msg_valid && msg_ready) begin
        msg_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_midi_msg_parser.sv
// Directed bench for midi_msg_parser; two instances cover both
// settings of the velocity-zero rewrite.
module tb_midi_msg_parser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;
  logic       msg_ready = 1'b1;

  logic       v1, ov1;
  logic [2:0] k1;
  logic [3:0] c1;
  logic [6:0] a1, b1;
  logic [7:0] dc1;

  logic       v0, ov0;
  logic [2:0] k0;
  logic [3:0] c0;
  logic [6:0] a0, b0;
  logic [7:0] dc0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [20:0] q1[$];
  logic [20:0] q0[$];
  int base1;
  int base0;

  always #5 clk = ~clk;

  midi_msg_parser #(.NOTE_ON_ZERO_IS_OFF(1'b1)) dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .msg_valid(v1), .msg_ready(msg_ready), .msg_kind(k1),
    .msg_chan(c1), .msg_d1(a1), .msg_d2(b1),
    .overflow(ov1), .drop_count(dc1)
  );

  midi_msg_parser #(.NOTE_ON_ZERO_IS_OFF(1'b0)) dut0 (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .msg_valid(v0), .msg_ready(msg_ready), .msg_kind(k0),
    .msg_chan(c0), .msg_d1(a0), .msg_d2(b0),
    .overflow(ov0), .drop_count(dc0)
  );

  // record every accepted message
  always @(posedge clk) begin
    if (!rst && v1 && msg_ready) q1.push_back({k1, c1, a1, b1});
    if (!rst && v0 && msg_ready) q0.push_back({k0, c0, a0, b0});
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic mark();
    base1 = q1.size();
    base0 = q0.size();
  endtask

  function automatic logic [20:0] m(input int k, input int c,
                                    input int d1, input int d2);
    return {k[2:0], c[3:0], d1[6:0], d2[6:0]};
  endfunction

  function automatic logic [20:0] e1(input int i);
    if (base1 + i < q1.size()) return q1[base1 + i];
    return '1;
  endfunction

  function automatic logic [20:0] e0(input int i);
    if (base0 + i < q0.size()) return q0[base0 + i];
    return '1;
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    check("rst_valid", v1, 0);
    check("rst_fields", {k1, c1, a1, b1}, 0);
    check("rst_ovf", ov1, 0);
    check("rst_drop", dc1, 0);
    rst = 1'b0;

    // basic note on with latency check
    mark();
    send(8'h90);
    send(8'h3C);
    check("t1_pre_valid", v1, 0);
    send(8'h64);
    check("t1_valid", v1, 1);
    check("t1_fields", {k1, c1, a1, b1}, m(1, 0, 'h3C, 'h64));
    @(negedge clk);
    check("t1_valid_drop", v1, 0);
    check("t1_count", q1.size() - base1, 1);

    // running status and velocity zero
    mark();
    send(8'h93); send(8'h40); send(8'h7F); send(8'h40); send(8'h00);
    @(negedge clk);
    check("t2_count", q1.size() - base1, 2);
    check("t2_m0", e1(0), m(1, 3, 'h40, 'h7F));
    check("t2_m1", e1(1), m(0, 3, 'h40, 0));
    check("t2_p0_count", q0.size() - base0, 2);
    check("t2_p0_m1", e0(1), m(1, 3, 'h40, 0));

    // real-time interleave
    mark();
    send(8'h90); send(8'hF8); send(8'h3C); send(8'hFE); send(8'h64);
    @(negedge clk);
    check("t3_count", q1.size() - base1, 1);
    check("t3_m0", e1(0), m(1, 0, 'h3C, 'h64));

    // program change with running status
    mark();
    send(8'hC5); send(8'h07); send(8'h09);
    @(negedge clk);
    check("t3_prog_count", q1.size() - base1, 2);
    check("t3_prog0", e1(0), m(4, 5, 'h07, 0));
    check("t3_prog1", e1(1), m(4, 5, 'h09, 0));

    // sysex clears running status
    mark();
    send(8'h90); send(8'h3C); send(8'h64); send(8'hF0);
    send(8'h01); send(8'h02); send(8'hF7); send(8'h3C); send(8'h64);
    @(negedge clk);
    check("t4_sysex_count", q1.size() - base1, 1);

    // system common clears running status
    mark();
    send(8'hE0); send(8'h00); send(8'hF3); send(8'h01); send(8'h40);
    @(negedge clk);
    check("t4_common_count", q1.size() - base1, 0);

    // backpressure
    msg_ready = 1'b0;
    send(8'hB1); send(8'h07); send(8'h10);
    send(8'hB1); send(8'h07); send(8'h20);
    check("t5_valid", v1, 1);
    check("t5_held", {k1, c1, a1, b1}, m(3, 1, 'h07, 'h10));
    check("t5_ovf", ov1, 1);
    check("t5_drop", dc1, 1);
    mark();
    msg_ready = 1'b1;
    @(negedge clk);
    check("t5_handshake", q1.size() - base1, 1);
    check("t5_drained", v1, 0);

    // saturation: one held message plus 300 drops
    msg_ready = 1'b0;
    send(8'hB1); send(8'h07); send(8'h10);
    for (int i = 0; i < 300; i++) begin
      send(8'h07);
      send(8'h11);
    end
    check("t5_sat", dc1, 255);
    check("t5_sat_held", {k1, c1, a1, b1}, m(3, 1, 'h07, 'h10));
    msg_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // asynchronous reset mid-message with a held message
    msg_ready = 1'b0;
    send(8'h90); send(8'h3C); send(8'h64);
    send(8'h90); send(8'h3C);
    check("t6_pre_valid", v1, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid", v1, 0);
    check("t6_rst_ovf", ov1, 0);
    check("t6_rst_drop", dc1, 0);
    check("t6_rst_fields", {k1, c1, a1, b1}, 0);
    @(negedge clk);
    rst = 1'b0;
    msg_ready = 1'b1;
    mark();
    send(8'h64);
    @(negedge clk);
    check("t6_after_rst", q1.size() - base1, 0);
    check("t6_after_valid", v1, 0);

    // abandoned partial is not a drop
    mark();
    send(8'h90); send(8'h3C); send(8'h80); send(8'h3C); send(8'h00);
    @(negedge clk);
    check("t7_count", q1.size() - base1, 1);
    check("t7_m0", e1(0), m(0, 0, 'h3C, 0));
    check("t7_ovf", ov1, 0);

    // idle bus bytes are ignored
    mark();
    rx_byte = 8'h90;
    repeat (3) @(negedge clk);
    rx_byte = 8'h3C;
    repeat (3) @(negedge clk);
    check("t8_idle", q1.size() - base1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
